// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, captures combinational imem data into a
// 2-entry buffer and hands instructions to decode over valid/ready.
module instr_fetch #(
  parameter int          ADDR_W   = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc
);

  // Handshake: decode takes the head on any rising edge where if_valid and
  // if_ready are both high; the head is stable while if_valid & ~if_ready.

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] PC_START = {RESET_PC[31:2], 2'b00};
  localparam logic [1:0]  FULL     = 2'd2;

  logic [31:0] pc;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic        pop;
  logic        push;

  assign imem_addr = pc[ADDR_W+1:2];
  assign if_valid  = (count != 2'd0);
  assign if_instr  = if_valid ? buf_instr[rd_ptr] : NOP;
  assign if_pc     = if_valid ? buf_pc[rd_ptr]    : 32'h0;

  assign pop  = if_valid & if_ready;
  // A full buffer may still accept a new word when the head leaves this cycle.
  assign push = fetch_en & ~redirect_valid & ((count != FULL) | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= PC_START;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= 32'h0;
        buf_instr[i] <= NOP;
      end
    end else if (redirect_valid) begin
      // Flush wins over everything, including a pop decode sees this cycle.
      pc     <= {redirect_pc[31:2], 2'b00};
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        buf_pc[wr_ptr]    <= pc;
        buf_instr[wr_ptr] <= imem_instr;
        wr_ptr            <= ~wr_ptr;
        pc                <= pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a main instance at PC 0 and a second one
// starting at 0x1FC to observe imem_addr wrap, both on the same stimulus.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;

  logic [6:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic [6:0]  w_imem_addr;
  logic [31:0] w_imem_instr;
  logic        w_if_valid;
  logic [31:0] w_if_instr;
  logic [31:0] w_if_pc;

  logic [31:0] mem [128];
  logic [63:0] exp_q [$];

  int checks;
  int failures;

  assign imem_instr   = mem[imem_addr];
  assign w_imem_instr = mem[w_imem_addr];

  instr_fetch #(.ADDR_W(7), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  instr_fetch #(.ADDR_W(7), .RESET_PC(32'h0000_01FC)) dut_wrap (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(w_if_valid), .if_ready(if_ready),
    .if_instr(w_if_instr), .if_pc(w_if_pc)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: at the negedge, a head that will be accepted at the next edge
  // is compared against the oldest expected {pc, instr}.
  task automatic step();
    logic [63:0] e;
    if (if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", if_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", if_pc, e[63:32]);
        chk("sb_instr", if_instr, e[31:0]);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_entry(input logic [31:0] p, input logic [31:0] ins);
    exp_q.push_back({p, ins});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0030_8193;

    rst = 1'b1;
    fetch_en = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 32'h0000_0013);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_addr", imem_addr, 7'd0);
    chk("rst_wrap_addr", w_imem_addr, 7'd127);

    // Stream from reset
    rst = 1'b0;
    fetch_en = 1'b1;
    if_ready = 1'b1;
    expect_entry(32'h0, 32'h0000_0013);
    expect_entry(32'h4, 32'h0010_0093);
    expect_entry(32'h8, 32'h0020_0113);
    expect_entry(32'hC, 32'h0030_8193);
    chk("pre_fetch_valid", if_valid, 1'b0);
    step();
    chk("first_valid", if_valid, 1'b1);
    chk("wrap_pc0", w_if_pc, 32'h0000_01FC);
    chk("wrap_instr0", w_if_instr, 32'hA000_007F);
    chk("wrap_addr_after", w_imem_addr, 7'd0);
    step();
    chk("wrap_pc1", w_if_pc, 32'h0000_0200);
    chk("wrap_instr1", w_if_instr, 32'h0000_0013);

    // Backpressure from the cycle the head is pc 4
    chk("bp_head_pc", if_pc, 32'h4);
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_instr", if_instr, 32'h0010_0093);
      chk("bp_hold_pc", if_pc, 32'h4);
    end
    chk("bp_addr", imem_addr, 7'd3);
    if_ready = 1'b1;
    step();
    chk("bp_rel_valid1", if_valid, 1'b1);
    step();
    chk("bp_rel_valid2", if_valid, 1'b1);
    step();
    chk("bp_queue_drained", exp_q.size(), 32'd0);

    // Redirect while the buffer is full
    if_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0009;
    step();
    chk("rd_flush_valid", if_valid, 1'b0);
    chk("rd_flush_addr", imem_addr, 7'd2);
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    expect_entry(32'h8, 32'h0020_0113);
    step();
    chk("rd_target_valid", if_valid, 1'b1);
    step();

    // Redirect together with a pop and fetch disabled
    chk("rd2_head_pc", if_pc, 32'hC);
    fetch_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0020;
    expect_entry(32'hC, 32'h0030_8193);
    step();
    redirect_valid = 1'b0;
    chk("rd2_valid", if_valid, 1'b0);
    chk("rd2_addr", imem_addr, 7'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd2_idle_valid", if_valid, 1'b0);
      chk("rd2_idle_addr", imem_addr, 7'd8);
    end
    fetch_en = 1'b1;
    expect_entry(32'h20, mem[8]);
    step();
    chk("rd2_resume_valid", if_valid, 1'b1);

    // Fill the buffer, then reset asynchronously between edges
    if_ready = 1'b0;
    step();
    step();
    chk("ar_pre_valid", if_valid, 1'b1);
    chk("ar_pre_addr", imem_addr, 7'd10);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", if_valid, 1'b0);
    chk("ar_instr", if_instr, 32'h0000_0013);
    chk("ar_pc", if_pc, 32'h0);
    chk("ar_addr", imem_addr, 7'd0);
    chk("ar_wrap_addr", w_imem_addr, 7'd127);
    exp_q.delete(0);
    @(negedge clk);
    rst = 1'b0;
    if_ready = 1'b1;
    expect_entry(32'h0, 32'h0000_0013);
    expect_entry(32'h4, 32'h0010_0093);
    step();
    chk("ar_restart_valid", if_valid, 1'b1);
    step();
    step();
    if_ready = 1'b0;
    fetch_en = 1'b0;
    step();
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that drives the word address into the 128-entry instruction memory and delivers fetched instructions to decode. It holds the program counter, captures the memory's combinational read data into a 2-entry fetch buffer, and presents instructions over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and reload the PC. It sits between the instruction memory and the decode stage.

## Interface
- ADDR_W, 7, instruction memory word-address width (memory depth 2^ADDR_W words)
- RESET_PC, 32'h0000_0000, byte PC loaded on reset (low 2 bits ignored)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- fetch_en  input  1  permits fetching; when 0, PC holds and no push occurs
- imem_addr  output  ADDR_W  word address to instruction memory, = pc[ADDR_W+1:2], combinational from pc
- imem_instr  input  32  instruction word returned combinationally for imem_addr
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  32  redirect target byte address
- if_valid  output  1  head of fetch buffer valid
- if_ready  input  1  decode accepts head this cycle
- if_instr  output  32  head instruction
- if_pc  output  32  byte PC of head instruction

## Operation
- State: pc (32 b), 2-entry buffer of {pc, instr}, count (0..2), read/write pointers (1 b each).
- pop = if_valid & if_ready.
- push = fetch_en & ~redirect_valid & (count < 2 | pop). On push: entry = {pc, imem_instr}; pc <= pc + 4.
- pc arithmetic modulo 2^32; imem_addr wraps naturally (pc 0x200 -> imem_addr 0 for ADDR_W=7).
- Redirect (highest priority): pc <= redirect_pc & ~32'h3; count <= 0; pointers <= 0; no push. A concurrent pop completes from decode's view; the entry is discarded with the flush.
- Simultaneous push and pop with count=2: allowed, count stays 2 (full throughput).
- Push and pop with count=1: count stays 1; head advances to the new entry.
- Pop with count=0: impossible (if_valid=0).
- fetch_en=0: pc held; buffer still drains via pop.
- if_valid = (count != 0); if_instr/if_pc driven from head entry. With count=0, if_instr = 32'h0000_0013 (NOP) and if_pc = 0.
- Head contents do not change while if_valid=1 and if_ready=0 (stable-while-stalled), except on redirect.

## Timing
- Reset (async assert, sync release): pc = RESET_PC & ~3, count = 0, pointers = 0, buffer storage cleared to NOP/0, if_valid = 0, if_instr = 32'h0000_0013, if_pc = 0, imem_addr = RESET_PC[ADDR_W+1:2].
- Fetch latency: an instruction captured at edge N is presented with if_valid=1 in cycle N+1.
- First instruction after reset release: if_valid=1 one cycle after the first edge with fetch_en=1.
- Redirect asserted in cycle N: at edge N, buffer empty and pc = target; cycle N+1 imem_addr = target word and if_valid=0; cycle N+2 if_valid=1 with target instruction.
- Sustained throughput: 1 instruction/cycle with if_ready held high.
- Backpressure: after if_ready drops, at most 2 instructions are buffered; pc stops advancing once count=2 with no pop.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.

## Test plan
- Reset/stream: memory words 0..3 = 00000013, 00100093, 00200113, 00308193; RESET_PC=0, fetch_en=1, if_ready=1 -> if_valid=1 from cycle 1, if_instr sequence 00000013, 00100093, 00200113, 00308193 on consecutive cycles, if_pc 0, 4, 8, C.
- Backpressure: if_ready=0 from the cycle if_pc=4 for 5 cycles -> if_instr/if_pc held at 00100093/4, pc stops at 0xC (count=2), imem_addr=3; on release, 4, 8, C delivered on back-to-back cycles with no gap.
- Redirect: redirect_valid=1 with redirect_pc=0x0000_0009 while buffer full -> buffer flushed, if_valid=0 for 1 cycle, next delivered if_pc=8, if_instr=00200113.
- Redirect concurrent with pop and with fetch_en=0: redirect wins, no push that cycle, pc = target; with fetch_en still 0 afterwards, if_valid stays 0 and pc holds.
- Wrap: RESET_PC=0x0000_01FC -> imem_addr=127 then 0; if_pc 0x1FC then 0x200, if_instr from word 0 = 00000013.
- Async reset mid-stream: assert rst between clock edges with count=2 -> if_valid=0, if_instr=00000013, imem_addr=0 immediately; fetch restarts from RESET_PC after release.
